// File: rtl/instr_fetch_if.sv
// Fetch-stage signal bundle: instruction-memory req/ack channel,
// downstream instruction handoff and branch/jump feedback into next-PC selection.
interface instr_fetch_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr_out;
   logic        instr_valid;
   logic        instr_ready;
   logic        branch_taken;
   logic [31:0] branch_imm32;
   logic        jump;
   logic [31:0] pc_out;
   logic [31:0] pc_plus4;
   logic        fetch_err;

   modport master (
      output imem_req, imem_addr,
      input  imem_ack, imem_rdata,
      output instr_out, instr_valid,
      input  instr_ready, branch_taken, branch_imm32, jump,
      output pc_out, pc_plus4, fetch_err
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_ack, imem_rdata,
      input  instr_out, instr_valid,
      output instr_ready, branch_taken, branch_imm32, jump,
      input  pc_out, pc_plus4, fetch_err
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC register, REQ/WAIT/HOLD fetch FSM and next-PC selection.
// Optional WAIT-state watchdog is built when IFETCH_TIMEOUT_EN is defined.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC       = 32'h0000_0000,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input logic           clk,
   input logic           rst_n,
   instr_fetch_if.master bus
);

   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,
      ST_WAIT = 2'd1,
      ST_HOLD = 2'd2
   } state_e;

   localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

   state_e      state_r, state_s;
   logic        req_r, req_s;
   logic [31:0] pc_r, pc_s;
   logic [31:0] instr_r, instr_s;
   logic        valid_r, valid_s;
   logic        err_r, err_s;
   logic [31:0] pc_plus4_s;
   logic [31:0] next_pc_s;
   logic        timeout_s;

   assign pc_plus4_s = pc_r + 32'd4;

   // Next-PC candidate; only committed in the HOLD cycle where downstream consumes.
   always_comb begin
      next_pc_s = pc_plus4_s;
      if (bus.jump) begin
         next_pc_s = {pc_plus4_s[31:28], instr_r[25:0], 2'b00};
      end else if (bus.branch_taken) begin
         next_pc_s = pc_plus4_s + {bus.branch_imm32[29:0], 2'b00};
      end else begin
         next_pc_s = pc_plus4_s;
      end
      next_pc_s[1:0] = 2'b00;
   end

`ifdef IFETCH_TIMEOUT_EN
   localparam int unsigned WD_W = (TIMEOUT_CYCLES > 32'd1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 32'd1);

   logic [WD_W-1:0] wd_r;

   assign timeout_s = (state_r == ST_WAIT) && (wd_r == WD_LAST);

   // Counts cycles spent in WAIT; any exit from WAIT restarts it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_r <= '0;
      end else if ((state_r == ST_WAIT) && (state_s == ST_WAIT)) begin
         wd_r <= wd_r + 1'b1;
      end else begin
         wd_r <= '0;
      end
   end
`else
   assign timeout_s = 1'b0;

   if (TIMEOUT_CYCLES == 32'd0) begin : g_no_watchdog
   end
`endif

   // Fetch FSM next state and next values of every registered output.
   always_comb begin
      state_s = state_r;
      req_s   = req_r;
      pc_s    = pc_r;
      instr_s = instr_r;
      valid_s = valid_r;
      err_s   = err_r;
      case (state_r)
         ST_REQ: begin
            req_s   = 1'b1;
            state_s = ST_WAIT;
         end
         ST_WAIT: begin
            // An ack on the watchdog's last cycle still wins over the timeout.
            if (bus.imem_ack) begin
               instr_s = bus.imem_rdata;
               valid_s = 1'b1;
               req_s   = 1'b0;
               state_s = ST_HOLD;
            end else if (timeout_s) begin
               err_s   = 1'b1;
               req_s   = 1'b0;
               state_s = ST_REQ;
            end else begin
               req_s = 1'b1;
            end
         end
         ST_HOLD: begin
            if (bus.instr_ready) begin
               valid_s = 1'b0;
               pc_s    = next_pc_s;
               state_s = ST_REQ;
            end else begin
               valid_s = 1'b1;
            end
         end
         default: begin
            req_s   = 1'b0;
            valid_s = 1'b0;
            state_s = ST_REQ;
         end
      endcase
   end

   // State and output registers; reset abandons any fetch in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_REQ;
         req_r   <= 1'b0;
         pc_r    <= RESET_PC_ALIGNED;
         instr_r <= 32'd0;
         valid_r <= 1'b0;
         err_r   <= 1'b0;
      end else begin
         state_r <= state_s;
         req_r   <= req_s;
         pc_r    <= pc_s;
         instr_r <= instr_s;
         valid_r <= valid_s;
         err_r   <= err_s;
      end
   end

   assign bus.imem_req    = req_r;
   assign bus.imem_addr   = pc_r;
   assign bus.instr_out   = instr_r;
   assign bus.instr_valid = valid_r;
   assign bus.pc_out      = pc_r;
   assign bus.pc_plus4    = pc_plus4_s;
   assign bus.fetch_err   = err_r;

endmodule
